// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up at the end.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes accepted
// RUN    | one multiplier/quotient bit per cycle, NBits cycles
// FIX    | sign correction, HI/LO write, done pulse
module mips_muldiv_unit #(
  parameter int NBits          = 32,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [NBits-1:0] i_opa,
  input  logic [NBits-1:0] i_opb,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [NBits-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [NBits-1:0] o_hi,
  output logic [NBits-1:0] o_lo
);

  localparam int CW = $clog2(NBits + 1);
  localparam logic [CW-1:0]        CNT_LOAD = CW'(NBits);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [NBits-1:0]     ONE_N    = {{(NBits-1){1'b0}}, 1'b1};
  localparam logic [2*NBits-1:0]   ONE_2N   = {{(2*NBits-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [NBits-1:0]   r_orig_a;
  logic [NBits-1:0]   r_a;
  logic [NBits-1:0]   r_b;
  logic [2*NBits-1:0] r_acc;
  logic [NBits-1:0]   r_hi;
  logic [NBits-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_signed_op;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [NBits-1:0]   w_mag_a;
  logic [NBits-1:0]   w_mag_b;
  logic [2*NBits-1:0] w_acc_init;
  logic [NBits:0]     w_mul_add;
  logic [NBits:0]     w_mul_sum;
  logic [2*NBits-1:0] w_mul_next;
  logic [NBits:0]     w_trial;
  logic               w_ge;
  logic [NBits-1:0]   w_diff;
  logic [2*NBits-1:0] w_div_next;
  logic               w_neg_q;
  logic [2*NBits-1:0] w_prod_neg;
  logic [NBits-1:0]   w_quo_neg;
  logic [NBits-1:0]   w_rem_neg;

  assign w_signed_op = SIGNED_SUPPORT && !i_op[0];
  assign w_neg_a     = w_signed_op & i_opa[NBits-1];
  assign w_neg_b     = w_signed_op & i_opb[NBits-1];
  assign w_mag_a     = w_neg_a ? (~i_opa) + ONE_N : i_opa;
  assign w_mag_b     = w_neg_b ? (~i_opb) + ONE_N : i_opb;
  // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
  assign w_acc_init  = i_op[1] ? {{NBits{1'b0}}, w_mag_a} : {{NBits{1'b0}}, w_mag_b};

  assign w_mul_add  = r_acc[0] ? {1'b0, r_a} : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*NBits-1:NBits]} + w_mul_add;
  assign w_mul_next = {w_mul_sum, r_acc[NBits-1:1]};

  // Partial remainder stays below the divisor, so the difference fits in NBits.
  assign w_trial    = {r_acc[2*NBits-1:NBits], r_acc[NBits-1]};
  assign w_ge       = w_trial >= {1'b0, r_b};
  assign w_diff     = w_trial[NBits-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff, r_acc[NBits-2:0], 1'b1}
                           : {w_trial[NBits-1:0], r_acc[NBits-2:0], 1'b0};

  assign w_neg_q    = r_neg_a ^ r_neg_b;
  assign w_prod_neg = (~r_acc) + ONE_2N;
  assign w_quo_neg  = (~r_acc[NBits-1:0]) + ONE_N;
  assign w_rem_neg  = (~r_acc[2*NBits-1:NBits]) + ONE_N;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_orig_a <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (i_start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_LOAD;
            r_is_div <= i_op[1];
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_orig_a <= i_opa;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_acc    <= w_acc_init;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_neg_q ? w_prod_neg : r_acc;
          end else if (r_b == '0) begin
            r_hi  <= r_orig_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_lo <= w_neg_q ? w_quo_neg : r_acc[NBits-1:0];
            r_hi <= r_neg_a ? w_rem_neg : r_acc[2*NBits-1:NBits];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (NBits=32): vector table, corner sequences,
// and random operations against a 64-bit arithmetic reference model.
module tb_mips_muldiv_unit;

  localparam int NB = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [NB-1:0] i_opa = '0;
  logic [NB-1:0] i_opb = '0;
  logic          i_hi_we = 1'b0;
  logic          i_lo_we = 1'b0;
  logic [NB-1:0] i_wdata = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_div_by_zero;
  logic [NB-1:0] o_hi;
  logic [NB-1:0] o_lo;

  int checks = 0;
  int failures = 0;

  mips_muldiv_unit #(.NBits(NB), .SIGNED_SUPPORT(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_opa(i_opa), .i_opb(i_opb), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]    op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] hi;
    logic [NB-1:0] lo;
    logic          dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // MIPS semantics expressed with plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                                output logic [NB-1:0] hi, output logic [NB-1:0] lo, output logic dz);
    longint     sa, sb;
    logic [63:0] ua, ub, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    case (op)
      2'b00: begin t = sa * sb; {hi, lo} = t; end
      2'b01: begin t = ua * ub; {hi, lo} = t; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1;
        end else if (op == 2'b10) begin
          t = sa / sb; lo = t[31:0];
          t = sa % sb; hi = t[31:0];
        end else begin
          t = ua / ub; lo = t[31:0];
          t = ua % ub; hi = t[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [NB-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Launches one operation from the current (posedge+1) point and follows it to done.
  // poke_start / poke_lo inject a start / MTLO write on that busy cycle (0 = none).
  task automatic do_op(input string nm, input logic [1:0] op, input logic [NB-1:0] a,
                       input logic [NB-1:0] b, input logic [NB-1:0] ehi, input logic [NB-1:0] elo,
                       input logic edz, input int poke_start, input int poke_lo, input bit keep);
    logic [NB-1:0] hi0, lo0;
    int  edges;
    bit  stable, busy_ok, seen;
    hi0 = o_hi; lo0 = o_lo;
    stable = 1'b1; busy_ok = 1'b1; seen = 1'b0; edges = 0;
    i_start = 1'b1; i_op = op; i_opa = a; i_opb = b;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_op = 2'($urandom); i_opa = $urandom; i_opb = $urandom;
    chk({nm, "_busy_e0"}, 64'(o_busy), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      if (o_hi !== hi0 || o_lo !== lo0) stable = 1'b0;
      if (o_busy !== 1'b1 || o_done !== 1'b0) busy_ok = 1'b0;
      if (k == poke_start) begin i_start = 1'b1; i_op = 2'b01; i_opa = 32'h1357; i_opb = 32'h3; end
      if (k == poke_start + 1) i_start = 1'b0;
      if (k == poke_lo) begin i_lo_we = 1'b1; i_hi_we = 1'b1; i_wdata = 32'h55; end
      if (k == poke_lo + 1) begin i_lo_we = 1'b0; i_hi_we = 1'b0; end
      @(posedge i_clk); #1;
      if (o_done === 1'b1) begin edges = k; seen = 1'b1; break; end
    end
    i_start = 1'b0; i_lo_we = 1'b0; i_hi_we = 1'b0;
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"}, 64'(edges), 64'd33);
    chk({nm, "_hi"}, 64'(o_hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(o_lo), 64'(elo));
    chk({nm, "_dz"}, 64'(o_div_by_zero), 64'(edz));
    chk({nm, "_busy_at_done"}, 64'(o_busy), 64'd0);
    chk({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({nm, "_hilo_stable"}, 64'(stable), 64'd1);
    if (!keep) begin
      @(posedge i_clk); #1;
      chk({nm, "_after_done"}, {61'd0, o_done, o_div_by_zero, o_busy}, 64'd0);
    end
  endtask

  initial begin
    logic [NB-1:0] mhi, mlo, prev_lo;
    logic          mdz;
    bit            seen;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{2'b00, 32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("reset_ctrl", {61'd0, o_busy, o_done, o_div_by_zero}, 64'd0);
    chk("reset_hilo", {o_hi, o_lo}, 64'd0);

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].dz, 0, 0, 1'b0);

    // MTHI/MTLO in IDLE
    prev_lo = o_lo;
    i_hi_we = 1'b1; i_wdata = 32'h1234;
    @(posedge i_clk); #1;
    i_hi_we = 1'b0;
    chk("mthi_hi", 64'(o_hi), 64'h1234);
    chk("mthi_lo_kept", 64'(o_lo), 64'(prev_lo));
    i_lo_we = 1'b1; i_wdata = 32'h55;
    @(posedge i_clk); #1;
    i_lo_we = 1'b0;
    chk("mtlo_lo", 64'(o_lo), 64'h55);

    // start ignored while busy; MTHI/MTLO ignored while busy
    do_op("ign_start", 2'b01, 32'h0001_2345, 32'h10, 32'h0, 32'h0012_3450, 1'b0, 5, 0, 1'b0);
    do_op("ign_mtlo", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 0, 5, 1'b0);

    // MTHI together with start: write lands now, result overwrites at FIX
    i_hi_we = 1'b1; i_wdata = 32'hABCD; i_start = 1'b1; i_op = 2'b01; i_opa = 32'd3; i_opb = 32'd5;
    @(posedge i_clk); #1;
    i_hi_we = 1'b0; i_start = 1'b0;
    chk("wr_start_hi", 64'(o_hi), 64'hABCD);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) seen = 1'b1;
    end
    chk("wr_start_done", 64'(seen), 64'd1);
    chk("wr_start_res", {o_hi, o_lo}, 64'd15);
    @(posedge i_clk); #1;

    // back-to-back: second start on the done cycle
    do_op("b2b_first", 2'b00, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0, 0, 0, 1'b1);
    do_op("b2b_second", 2'b11, 32'd50, 32'd6, 32'd2, 32'd8, 1'b0, 0, 0, 1'b0);

    // reset mid-divide
    i_start = 1'b1; i_op = 2'b10; i_opa = 32'd1000; i_opb = 32'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {61'd0, o_busy, o_done, o_div_by_zero}, 64'd0);
    chk("abort_hilo", {o_hi, o_lo}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    rop;
      logic [NB-1:0] ra, rb;
      rop = 2'($urandom);
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      model(rop, ra, rb, mhi, mlo, mdz);
      do_op($sformatf("rnd%0d_op%0d_%h_%h", n, rop, ra, rb), rop, ra, rb, mhi, mlo, mdz, 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers. It extends the pipelined MIPS datapath with MULT, MULTU, DIV, DIVU, MTHI and MTLO. The unit sits beside the EX stage: EX launches an operation with `start`, and hazard logic stalls any MFHI/MFLO or new mult/div while `busy` is high. Operand width is set by parameter, so the same unit serves 16/32/64-bit datapath variants.

## Interface
- `NBits`, 32, operand width; HI and LO are each `NBits`; must be even and ≥ 4.
- `SIGNED_SUPPORT`, 1, when 0, MULT/DIV execute as MULTU/DIVU (no sign handling logic).
- `clk`  in  1  single clock for the whole unit; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it forces all state to reset values immediately.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `opA`  in  NBits  rs value (multiplicand / dividend).
- `opB`  in  NBits  rt value (multiplier / divisor).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  NBits  MTHI/MTLO data.
- `busy`  out  1  operation in progress; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `div_by_zero`  out  1  pulses with `done` when DIV/DIVU had `opB` = 0.
- `HI`  out  NBits  high product / remainder.
- `LO`  out  NBits  low product / quotient.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `HI`=0, `LO`=0, iteration counter 0.
- States: IDLE, RUN, FIX.
  - IDLE→RUN when `start`=1.
  - RUN→FIX after `NBits` iterations.
  - FIX→IDLE always.
- On launch:
  - Operands and `op` are latched.
  - For signed ops with `SIGNED_SUPPORT`=1, operand magnitudes are latched (two's-complement abs, held in `NBits` unsigned), along with the result sign flags.
- Multiply:
  - Shift-add, one multiplier bit per RUN cycle, into a 2·`NBits` accumulator.
  - Product sign is signA XOR signB.
- Divide:
  - Restoring, one quotient bit per RUN cycle.
  - Quotient sign is signA XOR signB; remainder sign is signA.
- FIX state:
  - Applies sign correction.
  - Writes HI/LO.
  - Registers `done`=1 and `div_by_zero`.
- Divide by zero (`opB`=0, DIV or DIVU):
  - HI = `opA` (original, unmodified); LO = all ones.
  - `div_by_zero`=1 with `done`.
  - Same latency as a normal divide.
- Signed overflow: most-negative / −1 gives LO = most-negative (e.g. 0x80000000), HI = 0.
- `start` while busy (RUN/FIX): ignored; no queuing.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` load `wdata` into HI/LO at the next edge.
  - Ignored while `busy`=1.
- `start` and `hi_we`/`lo_we` in the same IDLE cycle: the write takes effect and the operation starts; the operation's result overwrites both registers at FIX.
- Reset asserted mid-operation: everything returns to reset values; no `done` pulse for the aborted operation.

## Timing
- `start` is sampled at edge E0; `busy`=1 from just after E0.
- RUN iterations occur at edges E1..E`NBits`; FIX is at edge E`NBits`+1.
- At E`NBits`+1, HI/LO update, `done`=1, `div_by_zero` is valid, and `busy` drops to 0. `done` lasts exactly one cycle.
- Total latency from start to result: `NBits`+1 edges (33 for `NBits`=32). Busy period: `NBits`+1 cycles.
- Back-to-back: `start` may be high in the cycle where `done`=1. It is accepted (state is IDLE) and `busy` re-asserts after that edge, so each operation occupies `NBits`+1 cycles.
- HI/LO are stable (hold their previous values) throughout RUN. MFHI/MFLO reads are valid whenever `busy`=0.

## Test plan
- Reset then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high 33 cycles; `done` pulse at edge 33 after the start edge; HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3 (0xFFFFFFFD) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV −7 ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 ÷ 7 -> LO=14, HI=2; DIV 0x80000000 ÷ 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 ÷ 0 -> HI=5, LO=0xFFFFFFFF, `div_by_zero`=1 for exactly the `done` cycle.
- Busy and reset handling:
  - Pulse `start` with new operands at cycle 5 of a running op -> ignored; first result unchanged.
  - Assert `reset` low at cycle 10 of a DIV -> `busy`=0, HI=LO=0 immediately, no `done`.
- MTHI 0x1234 in IDLE -> HI=0x1234 next edge; MTLO 0x55 while busy -> LO unchanged; back-to-back `start` on the `done` cycle -> second result 33 cycles later.
